// File: rtl/me_feeder_pkg.sv
// me_feeder_pkg: frame geometry, derived constants and fetch-FSM states for me_pixel_feeder
package me_feeder_pkg;
  localparam int DEF_FRAME_W = 4096;
  localparam int DEF_FRAME_H = 2160;
  localparam int DEF_PF_DEPTH = 4;
  localparam int BLK_EDGE = 8;
  localparam int WORDS_PER_BLK = 16;
  localparam int CUR_WORDS_PER_ROW = DEF_FRAME_W / 4;
  localparam int REF_WORDS = DEF_FRAME_W * DEF_FRAME_H / 8;
  localparam int CUR_AW = $clog2(DEF_FRAME_W * DEF_FRAME_H / 4);
  localparam int REF_AW = $clog2(REF_WORDS);
  typedef enum logic [1:0] {IDLE, FILL, RUN} fetch_state_e;
  function automatic int clog2_1(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/feeder_prefetch_q.sv
// feeder_prefetch_q: registered prefetch FIFO whose head holds the last popped word while empty
module feeder_prefetch_q #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] last_q, last_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_pop;
  assign empty = cnt_q == '0;
  assign do_pop = pop & ~empty;
  assign head = empty ? last_q : mem_q[rp_q];
  assign count = cnt_q;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wp_q] = din;
    wp_d = wp_q + AW'(push);
    rp_d = rp_q + AW'(do_pop);
    cnt_d = cnt_q + CW'(push) - CW'(do_pop);
    last_d = do_pop ? mem_q[rp_q] : last_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      mem_q <= '{default: '0};
      last_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      last_q <= last_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/me_pixel_feeder.sv
// me_pixel_feeder: block-scan cur / linear ref prefetching pixel source; ME_FEEDER_UNDERRUN_CNT_EN adds underrun_cnt
module me_pixel_feeder
  import me_feeder_pkg::*;
#(
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int FRAME_H = DEF_FRAME_H,
  parameter int PF_DEPTH = DEF_PF_DEPTH,
  localparam int CAW = clog2_1(FRAME_W * FRAME_H / 4),
  localparam int RAW = clog2_1(FRAME_W * FRAME_H / 8)
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           need_cur,
  input  logic           need_ref,
  output logic [31:0]    cur_in,
  output logic [63:0]    ref_in,
  output logic           cur_mem_en,
  output logic [CAW-1:0] cur_mem_addr,
  input  logic [31:0]    cur_mem_rdata,
  output logic           ref_mem_en,
  output logic [RAW-1:0] ref_mem_addr,
  input  logic [63:0]    ref_mem_rdata,
  output logic           underrun
`ifdef ME_FEEDER_UNDERRUN_CNT_EN
  ,
  output logic [15:0]    underrun_cnt
`endif
);
  localparam int NBX = FRAME_W / BLK_EDGE;
  localparam int NBY = FRAME_H / BLK_EDGE;
  localparam int ROW_W = FRAME_W / 4;
  localparam int NREF = FRAME_W * FRAME_H / 8;
  localparam int BXW = clog2_1(NBX);
  localparam int BYW = clog2_1(NBY);
  localparam int KW = $clog2(WORDS_PER_BLK);
  localparam int QCW = $clog2(PF_DEPTH) + 1;
  localparam int SW = QCW + 1;
  fetch_state_e cur_st_q, cur_st_d, ref_st_q, ref_st_d;
  logic cur_en_q, cur_en_d, cur_vld_q, cur_vld_d;
  logic ref_en_q, ref_en_d, ref_vld_q, ref_vld_d;
  logic [CAW-1:0] cur_addr_q, cur_addr_d, cur_gen;
  logic [RAW-1:0] ref_addr_q, ref_addr_d, rp_q, rp_d;
  logic [BXW-1:0] bx_q, bx_d;
  logic [BYW-1:0] by_q, by_d;
  logic [KW-1:0] k_q, k_d;
  logic underrun_q, underrun_d;
  logic [QCW-1:0] cur_cnt, ref_cnt;
  logic cur_empty, ref_empty, cur_pop, ref_pop, cur_issue, ref_issue;
  logic [SW-1:0] cur_sum, ref_sum;
  logic blk_end, bx_last, by_last, rp_last;
  feeder_prefetch_q #(.WIDTH(32), .DEPTH(PF_DEPTH)) u_cur_q (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .push   (cur_vld_q),
    .din    (cur_mem_rdata),
    .pop    (need_cur),
    .head   (cur_in),
    .count  (cur_cnt),
    .empty  (cur_empty)
  );
  feeder_prefetch_q #(.WIDTH(64), .DEPTH(PF_DEPTH)) u_ref_q (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .push   (ref_vld_q),
    .din    (ref_mem_rdata),
    .pop    (need_ref),
    .head   (ref_in),
    .count  (ref_cnt),
    .empty  (ref_empty)
  );
  always_comb begin
    cur_pop = need_cur & ~cur_empty;
    ref_pop = need_ref & ~ref_empty;
    cur_sum = SW'(cur_cnt) + SW'(cur_vld_q) + SW'(cur_en_q);
    ref_sum = SW'(ref_cnt) + SW'(ref_vld_q) + SW'(ref_en_q);
    cur_issue = cur_sum < SW'(PF_DEPTH) + SW'(cur_st_q == RUN && cur_pop);
    ref_issue = ref_sum < SW'(PF_DEPTH) + SW'(ref_st_q == RUN && ref_pop);
    cur_st_d = cur_st_q == IDLE ? FILL : (cur_st_q == FILL && cur_sum >= SW'(PF_DEPTH - 1)) ? RUN : cur_st_q;
    ref_st_d = ref_st_q == IDLE ? FILL : (ref_st_q == FILL && ref_sum >= SW'(PF_DEPTH - 1)) ? RUN : ref_st_q;
    cur_en_d = cur_issue;
    ref_en_d = ref_issue;
    cur_vld_d = cur_en_q;
    ref_vld_d = ref_en_q;
    cur_gen = CAW'((32'(by_q) * BLK_EDGE + 32'(k_q[KW-1:1])) * ROW_W + 32'(bx_q) * 2 + 32'(k_q[0]));
    blk_end = k_q == KW'(WORDS_PER_BLK - 1);
    bx_last = bx_q == BXW'(NBX - 1);
    by_last = by_q == BYW'(NBY - 1);
    rp_last = rp_q == RAW'(NREF - 1);
    cur_addr_d = cur_issue ? cur_gen : cur_addr_q;
    k_d = cur_issue ? k_q + 1'b1 : k_q;
    bx_d = cur_issue && blk_end ? (bx_last ? '0 : bx_q + 1'b1) : bx_q;
    by_d = cur_issue && blk_end && bx_last ? (by_last ? '0 : by_q + 1'b1) : by_q;
    ref_addr_d = ref_issue ? rp_q : ref_addr_q;
    rp_d = ref_issue ? (rp_last ? '0 : rp_q + 1'b1) : rp_q;
    underrun_d = underrun_q | (need_cur & cur_empty) | (need_ref & ref_empty);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cur_st_q <= IDLE;
      ref_st_q <= IDLE;
      cur_en_q <= 1'b0;
      ref_en_q <= 1'b0;
      cur_vld_q <= 1'b0;
      ref_vld_q <= 1'b0;
      cur_addr_q <= '0;
      ref_addr_q <= '0;
      k_q <= '0;
      bx_q <= '0;
      by_q <= '0;
      rp_q <= '0;
      underrun_q <= 1'b0;
    end else begin
      cur_st_q <= cur_st_d;
      ref_st_q <= ref_st_d;
      cur_en_q <= cur_en_d;
      ref_en_q <= ref_en_d;
      cur_vld_q <= cur_vld_d;
      ref_vld_q <= ref_vld_d;
      cur_addr_q <= cur_addr_d;
      ref_addr_q <= ref_addr_d;
      k_q <= k_d;
      bx_q <= bx_d;
      by_q <= by_d;
      rp_q <= rp_d;
      underrun_q <= underrun_d;
    end
  end
  assign cur_mem_en = cur_en_q;
  assign ref_mem_en = ref_en_q;
  assign cur_mem_addr = cur_addr_q;
  assign ref_mem_addr = ref_addr_q;
  assign underrun = underrun_q;
`ifdef ME_FEEDER_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;
  logic [16:0] usum;
  always_comb begin
    usum = {1'b0, ucnt_q} + 17'(need_cur & cur_empty) + 17'(need_ref & ref_empty);
    ucnt_d = usum[16] ? 16'hFFFF : usum[15:0];
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) ucnt_q <= '0;
    else ucnt_q <= ucnt_d;
  end
  assign underrun_cnt = ucnt_q;
`endif
endmodule

// File: tb/tb_me_pixel_feeder.sv
// tb_me_pixel_feeder: random-need bench with a strobe/arrival scoreboard for the 32x16 frame build
module tb_me_pixel_feeder;
  localparam int FW = 32;
  localparam int FH = 16;
  localparam int PD = 4;
  localparam int NCUR = FW * FH / 4;
  localparam int NREF = FW * FH / 8;
  localparam int CAW = $clog2(NCUR);
  localparam int RAW = $clog2(NREF);
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic need_cur = 1'b0;
  logic need_ref = 1'b0;
  logic [31:0] cur_in, cur_mem_rdata;
  logic [63:0] ref_in, ref_mem_rdata;
  logic cur_mem_en, ref_mem_en, underrun;
  logic [CAW-1:0] cur_mem_addr;
  logic [RAW-1:0] ref_mem_addr;
`ifdef ME_FEEDER_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif
  me_pixel_feeder #(.FRAME_W(FW), .FRAME_H(FH), .PF_DEPTH(PD)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .need_cur     (need_cur),
    .need_ref     (need_ref),
    .cur_in       (cur_in),
    .ref_in       (ref_in),
    .cur_mem_en   (cur_mem_en),
    .cur_mem_addr (cur_mem_addr),
    .cur_mem_rdata(cur_mem_rdata),
    .ref_mem_en   (ref_mem_en),
    .ref_mem_addr (ref_mem_addr),
    .ref_mem_rdata(ref_mem_rdata),
    .underrun     (underrun)
`ifdef ME_FEEDER_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );
  always #5 clk = ~clk;
  logic [31:0] cmem [NCUR];
  logic [63:0] rmem [NREF];
  always @(posedge clk) begin
    cur_mem_rdata <= cur_mem_en ? cmem[cur_mem_addr] : 32'hDEAD_BEEF;
    ref_mem_rdata <= ref_mem_en ? rmem[ref_mem_addr] : 64'hDEAD_BEEF_DEAD_BEEF;
  end
  int total = 0;
  int bad = 0;
  int cyc;
  int cur_seq [NCUR];
  int cur_iss, ref_iss, exp_ucnt;
  int cq_t[$];
  int rq_t[$];
  logic [31:0] cq_d[$];
  logic [63:0] rq_d[$];
  logic [31:0] cur_last;
  logic [63:0] ref_last;
  logic exp_unr;
  int pat [5] = '{1, 0, 1, 1, 0};
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    cq_t.delete();
    cq_d.delete();
    rq_t.delete();
    rq_d.delete();
    cur_iss = 0;
    ref_iss = 0;
    cur_last = '0;
    ref_last = '0;
    exp_unr = 1'b0;
    exp_ucnt = 0;
    cyc = 0;
  endtask
  task automatic do_reset();
    need_cur = 1'b0;
    need_ref = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_cur_in", cur_in, 0);
    chk("rst_ref_in", ref_in, 0);
    chk("rst_cur_en", cur_mem_en, 0);
    chk("rst_ref_en", ref_mem_en, 0);
    chk("rst_cur_addr", cur_mem_addr, 0);
    chk("rst_ref_addr", ref_mem_addr, 0);
    chk("rst_underrun", underrun, 0);
    model_reset();
    rst_n = 1'b1;
  endtask
  task automatic cycle(input logic nc, input logic nr);
    logic ca, ra;
    chk("underrun", underrun, exp_unr);
`ifdef ME_FEEDER_UNDERRUN_CNT_EN
    chk("underrun_cnt", underrun_cnt, exp_ucnt);
`endif
    if (cur_mem_en) begin
      chk("cur_addr", cur_mem_addr, cur_seq[cur_iss % NCUR]);
      cq_t.push_back(cyc + 2);
      cq_d.push_back(cmem[cur_seq[cur_iss % NCUR]]);
      cur_iss++;
    end
    if (ref_mem_en) begin
      chk("ref_addr", ref_mem_addr, ref_iss % NREF);
      rq_t.push_back(cyc + 2);
      rq_d.push_back(rmem[ref_iss % NREF]);
      ref_iss++;
    end
    chk("cur_occ", cq_t.size() <= PD, 1);
    chk("ref_occ", rq_t.size() <= PD, 1);
    ca = cq_t.size() > 0 && cq_t[0] <= cyc;
    ra = rq_t.size() > 0 && rq_t[0] <= cyc;
    chk("cur_in", cur_in, ca ? cq_d[0] : cur_last);
    chk("ref_in", ref_in, ra ? rq_d[0] : ref_last);
    need_cur = nc;
    need_ref = nr;
    if (nc) begin
      if (ca) begin
        cur_last = cq_d.pop_front();
        void'(cq_t.pop_front());
      end else begin
        exp_unr = 1'b1;
        if (exp_ucnt < 65535) exp_ucnt++;
      end
    end
    if (nr) begin
      if (ra) begin
        ref_last = rq_d.pop_front();
        void'(rq_t.pop_front());
      end else begin
        exp_unr = 1'b1;
        if (exp_ucnt < 65535) exp_ucnt++;
      end
    end
    @(negedge clk);
    cyc++;
  endtask
  initial begin
    for (int i = 0; i < NCUR; i++) cmem[i] = $urandom;
    for (int i = 0; i < NREF; i++) rmem[i] = {$urandom, $urandom};
    for (int by = 0; by < FH / 8; by++)
      for (int bx = 0; bx < FW / 8; bx++)
        for (int k = 0; k < 16; k++)
          cur_seq[(by * (FW / 8) + bx) * 16 + k] = ((by * 8 + k / 2) * FW + bx * 8 + (k % 2) * 4) / 4;
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      chk("idle_cur_en", cur_mem_en, cyc >= 1 && cyc <= 4);
      chk("idle_ref_en", ref_mem_en, cyc >= 1 && cyc <= 4);
      cycle(1'b0, 1'b0);
    end
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1);
    chk("cont_no_underrun", underrun, 0);
    for (int i = 0; i < 200; i++) cycle(1'($urandom_range(0, 1)), 1'(pat[i % 5]));
    do_reset();
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    chk("unr_cur_in", cur_in, 0);
    chk("unr_flag", underrun, 1);
    for (int i = 0; i < 60; i++) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk("unr_sticky", underrun, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
